// File: rtl/logip_pkg.sv
// Shared types and constants for the UART word transmitter.
// Provides the serializer state encoding and the byte-selection helper.
package logip_pkg;

   localparam int WORD_WIDTH     = 32;
   localparam int BYTES_PER_WORD = 4;

   typedef enum bit [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   // Lowest byte index >= from whose disable bit is clear; bit 2 flags "found".
   function automatic logic [2:0] first_enabled(input logic [3:0] dis, input logic [2:0] from);
      logic [2:0] res;
      res = 3'b000;
      for (int i = BYTES_PER_WORD - 1; i >= 0; i--) begin
         if (i >= int'(from) && !dis[i]) begin
            res = {1'b1, 2'(i)};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serializer with its own baud counter.
// A strobe during the last stop-bit cycle chains the next byte with no gap.
module uart_byte_tx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk_i,
   input  logic       rst_in,
   input  logic       byte_stb_i,
   input  logic [7:0] byte_data_i,
   output logic       byte_done_o,
   output logic       busy_o,
   output logic       tx_o
);
   import logip_pkg::*;

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   tx_state_t      state, state_next;
   logic [BW-1:0]  baud_cnt, baud_next;
   logic [2:0]     bit_cnt, bit_next;
   logic [7:0]     shift, shift_next;
   logic           tx_q, tx_next;
   logic           bit_end;

   assign bit_end     = (baud_cnt == BAUD_LAST);
   assign byte_done_o = (state == TX_STOP) && bit_end;
   assign busy_o      = (state != TX_IDLE);
   assign tx_o        = tx_q;

   always_ff @(posedge clk_i) begin
      if (!rst_in) begin
         state    <= TX_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         tx_q     <= 1'b1;
      end else begin
         state    <= state_next;
         baud_cnt <= baud_next;
         bit_cnt  <= bit_next;
         shift    <= shift_next;
         tx_q     <= tx_next;
      end
   end

   // The line value is registered, so it is updated on the edge that opens each bit.
   always_comb begin
      state_next = state;
      baud_next  = baud_cnt + 1'b1;
      bit_next   = bit_cnt;
      shift_next = shift;
      tx_next    = tx_q;
      case (state)
         TX_IDLE: begin
            baud_next = '0;
            if (byte_stb_i) begin
               state_next = TX_START;
               shift_next = byte_data_i;
               tx_next    = 1'b0;
            end
         end
         TX_START: begin
            if (bit_end) begin
               baud_next  = '0;
               state_next = TX_DATA;
               bit_next   = 3'd0;
               tx_next    = shift[0];
               shift_next = {1'b0, shift[7:1]};
            end
         end
         TX_DATA: begin
            if (bit_end) begin
               baud_next = '0;
               if (bit_cnt == 3'd7) begin
                  state_next = TX_STOP;
                  tx_next    = 1'b1;
               end else begin
                  bit_next   = bit_cnt + 3'd1;
                  tx_next    = shift[0];
                  shift_next = {1'b0, shift[7:1]};
               end
            end
         end
         TX_STOP: begin
            if (bit_end) begin
               baud_next = '0;
               if (byte_stb_i) begin
                  state_next = TX_START;
                  shift_next = byte_data_i;
                  tx_next    = 1'b0;
               end else begin
                  state_next = TX_IDLE;
                  tx_next    = 1'b1;
               end
            end
         end
         default: state_next = TX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_word_tx.sv
// Sends one 32-bit word as four 8N1 bytes, byte 0 first.
// Optional byte-skip mask enabled by defining UART_GROUP_MASK_EN.
module uart_word_tx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic        clk_i,
   input  logic        rst_in,
   input  logic [31:0] data_i,
   input  logic        stb_i,
`ifdef UART_GROUP_MASK_EN
   input  logic [3:0]  group_dis_i,
`endif
   output logic        rdy_o,
   output logic        tx_o
);
   import logip_pkg::*;

   logic [WORD_WIDTH-1:0] word_q, word_next;
   logic [3:0]            mask_q, mask_next, mask_in;
   logic [1:0]            byte_idx, idx_next;
   logic                  rdy_q, rdy_next;
   logic                  byte_stb, byte_done, byte_busy;
   logic [7:0]            byte_data;
   logic [2:0]            first_sel, next_sel;

`ifdef UART_GROUP_MASK_EN
   assign mask_in = group_dis_i;
`else
   assign mask_in = 4'b0000;
`endif

   assign first_sel = first_enabled(mask_in, 3'd0);
   assign next_sel  = first_enabled(mask_q, {1'b0, byte_idx} + 3'd1);
   assign rdy_o     = rdy_q;

   always_ff @(posedge clk_i) begin
      if (!rst_in) begin
         word_q   <= '0;
         mask_q   <= '0;
         byte_idx <= '0;
         rdy_q    <= 1'b1;
      end else begin
         word_q   <= word_next;
         mask_q   <= mask_next;
         byte_idx <= idx_next;
         rdy_q    <= rdy_next;
      end
   end

   // The first byte is taken straight from data_i so its start bit begins on the accept edge.
   always_comb begin
      word_next = word_q;
      mask_next = mask_q;
      idx_next  = byte_idx;
      rdy_next  = rdy_q;
      byte_stb  = 1'b0;
      byte_data = word_q[{byte_idx, 3'b000} +: 8];
      if (stb_i && rdy_q) begin
         word_next = data_i;
         mask_next = mask_in;
         rdy_next  = 1'b0;
         if (first_sel[2]) begin
            byte_stb  = 1'b1;
            idx_next  = first_sel[1:0];
            byte_data = data_i[{first_sel[1:0], 3'b000} +: 8];
         end
      end else if (!rdy_q) begin
         if (byte_done) begin
            if (next_sel[2]) begin
               byte_stb  = 1'b1;
               idx_next  = next_sel[1:0];
               byte_data = word_q[{next_sel[1:0], 3'b000} +: 8];
            end else begin
               rdy_next = 1'b1;
            end
         end else if (!byte_busy) begin
            rdy_next = 1'b1;
         end
      end
   end

   uart_byte_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte_tx (
      .clk_i       (clk_i),
      .rst_in      (rst_in),
      .byte_stb_i  (byte_stb),
      .byte_data_i (byte_data),
      .byte_done_o (byte_done),
      .busy_o      (byte_busy),
      .tx_o        (tx_o)
   );

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: line waveform, decoded bytes and rdy timing vs a bit-level model.
// Mask scenarios are exercised only when UART_GROUP_MASK_EN is defined.
module tb_uart_word_tx;

   localparam int CPB  = 4;
   localparam int CPB2 = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stb;
   logic [31:0] data;
`ifdef UART_GROUP_MASK_EN
   logic [3:0]  dis_in;
`endif
   logic        rdy1, tx1, rdy2, tx2;
   logic        rdy_s, tx_s;
   bit          sel;

   int checks   = 0;
   int failures = 0;
   int low_len;

   bit         exp_bits[$];
   logic [7:0] exp_bytes[$];
   logic [7:0] got_bytes[$];
   bit         cap_tx[$];

   always #5 clk = ~clk;

   assign rdy_s = sel ? rdy2 : rdy1;
   assign tx_s  = sel ? tx2  : tx1;

   uart_word_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk_i       (clk),
      .rst_in      (rst_n),
      .data_i      (data),
      .stb_i       (stb),
`ifdef UART_GROUP_MASK_EN
      .group_dis_i (dis_in),
`endif
      .rdy_o       (rdy1),
      .tx_o        (tx1)
   );

   uart_word_tx #(.CLKS_PER_BIT(CPB2)) dut2 (
      .clk_i       (clk),
      .rst_in      (rst_n),
      .data_i      (data),
      .stb_i       (stb),
`ifdef UART_GROUP_MASK_EN
      .group_dis_i (dis_in),
`endif
      .rdy_o       (rdy2),
      .tx_o        (tx2)
   );

   // Reference: each enabled byte becomes start 0, eight data bits LSB first, stop 1.
   task automatic model_word(input logic [31:0] w, input logic [3:0] dis);
      logic [7:0] v;
      for (int b = 0; b < 4; b++) begin
         if (!dis[b]) begin
            v = w[8*b +: 8];
            exp_bytes.push_back(v);
            exp_bits.push_back(1'b0);
            for (int j = 0; j < 8; j++) exp_bits.push_back(v[j]);
            exp_bits.push_back(1'b1);
         end
      end
   endtask

   task automatic clear_model();
      exp_bits.delete();
      exp_bytes.delete();
      cap_tx.delete();
   endtask

   // Behavioural UART receiver: find falling edges, sample mid-bit.
   task automatic decode(input int cpb);
      int i, last;
      bit prev;
      logic [7:0] v;
      got_bytes.delete();
      prev = 1'b1;
      i = 0;
      while (i < cap_tx.size()) begin
         if (prev && !cap_tx[i]) begin
            last = i + 9*cpb + cpb/2;
            if (last >= cap_tx.size()) break;
            for (int j = 0; j < 8; j++) v[j] = cap_tx[i + cpb*(1+j) + cpb/2];
            got_bytes.push_back(v);
            i = last;
            prev = cap_tx[i];
            i++;
         end else begin
            prev = cap_tx[i];
            i++;
         end
      end
   endtask

   task automatic check_bytes(input int cpb, input string name);
      int n;
      decode(cpb);
      checks++;
      if (got_bytes.size() != exp_bytes.size()) begin
         failures++;
         $display("[TB] FAIL %s byte_count: got %0d expected %0d", name, got_bytes.size(), exp_bytes.size());
      end
      n = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (got_bytes[i] !== exp_bytes[i]) begin
            failures++;
            $display("[TB] FAIL %s byte%0d: got %02h expected %02h", name, i, got_bytes[i], exp_bytes[i]);
         end
      end
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (rdy_s !== 1'b1 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (rdy_s !== 1'b1) begin
         failures++;
         $display("[TB] FAIL %s wait_ready: rdy_o got %b expected 1 within 2000 cycles", name, rdy_s);
      end
   endtask

   task automatic run_word(input logic [31:0] w, input logic [3:0] dis, input int cpb,
                           input int inject_at, input string name);
      int enabled, exp_len, mism, k;
      bit e;
      clear_model();
      model_word(w, dis);
      enabled = exp_bytes.size();
      exp_len = (enabled == 0) ? 1 : 10*cpb*enabled;
      wait_ready(name);
      data = w;
`ifdef UART_GROUP_MASK_EN
      dis_in = dis;
`endif
      stb = 1'b1;
      @(posedge clk); #1;
      stb = 1'b0;
      data = $urandom();
      low_len = -1;
      k = 0;
      while (low_len < 0 && k <= 40*cpb + 20) begin
         cap_tx.push_back(tx_s);
         if (rdy_s === 1'b1) begin
            low_len = k;
         end else begin
            if (k == inject_at) begin
               stb  = 1'b1;
               data = 32'hFFFF_FFFF;
            end else begin
               stb = 1'b0;
            end
            @(posedge clk); #1;
            k++;
         end
      end
      stb = 1'b0;
      checks++;
      if (low_len !== exp_len) begin
         failures++;
         $display("[TB] FAIL %s rdy_low_time: got %0d expected %0d", name, low_len, exp_len);
      end
      mism = 0;
      for (int i = 0; i < cap_tx.size(); i++) begin
         e = (i >= exp_len || enabled == 0) ? 1'b1 : exp_bits[i / cpb];
         if (cap_tx[i] !== e) mism++;
      end
      checks++;
      if (mism != 0) begin
         failures++;
         $display("[TB] FAIL %s waveform: got %0d wrong cycles expected 0", name, mism);
      end
      check_bytes(cpb, name);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      stb   = 1'b0;
      data  = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rdy1 !== 1'b1 || tx1 !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_cpb4: rdy=%b tx=%b expected rdy=1 tx=1", rdy1, tx1);
      end
      checks++;
      if (rdy2 !== 1'b1 || tx2 !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_cpb2: rdy=%b tx=%b expected rdy=1 tx=1", rdy2, tx2);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_word();
      sel = 1'b0;
      run_word(32'h1234_5678, 4'b0000, CPB, -1, "word_12345678");
      for (int i = 0; i < 3; i++) run_word($urandom(), 4'b0000, CPB, -1, "word_random");
   endtask

   task automatic test_ignored_strobe();
      sel = 1'b0;
      run_word(32'h1234_5678, 4'b0000, CPB, 20, "ignored_strobe");
   endtask

   task automatic test_back_to_back();
      logic [31:0] wa, wb;
      int L, k, first_high, idle, end_k, mism;
      bit second, e;
      wa = 32'hA5A5_A5A5;
      wb = 32'h0F0F_0F0F;
      L = 40*CPB;
      sel = 1'b0;
      clear_model();
      model_word(wa, 4'b0000);
      model_word(wb, 4'b0000);
      wait_ready("b2b");
      data = wa;
`ifdef UART_GROUP_MASK_EN
      dis_in = 4'b0000;
`endif
      stb = 1'b1;
      @(posedge clk); #1;
      data = wb;
      first_high = -1; idle = 0; end_k = -1; second = 1'b0; k = 0;
      while (end_k < 0 && k < 2*L + 40) begin
         cap_tx.push_back(tx_s);
         if (rdy_s === 1'b1) begin
            if (second) end_k = k;
            else begin
               if (first_high < 0) first_high = k;
               idle++;
            end
         end else if (first_high >= 0 && !second) begin
            second = 1'b1;
            stb = 1'b0;
         end
         if (end_k < 0) begin
            @(posedge clk); #1;
            k++;
         end
      end
      stb = 1'b0;
      checks++;
      if (first_high != L) begin
         failures++;
         $display("[TB] FAIL b2b first_low_time: got %0d expected %0d", first_high, L);
      end
      checks++;
      if (idle != 1) begin
         failures++;
         $display("[TB] FAIL b2b idle_cycles: got %0d expected 1", idle);
      end
      checks++;
      if (end_k != 2*L + 1) begin
         failures++;
         $display("[TB] FAIL b2b end_time: got %0d expected %0d", end_k, 2*L + 1);
      end
      mism = 0;
      for (int i = 0; i < cap_tx.size(); i++) begin
         if (i < L)              e = exp_bits[i / CPB];
         else if (i == L)        e = 1'b1;
         else if (i < 2*L + 1)   e = exp_bits[40 + (i - L - 1) / CPB];
         else                    e = 1'b1;
         if (cap_tx[i] !== e) mism++;
      end
      checks++;
      if (mism != 0) begin
         failures++;
         $display("[TB] FAIL b2b waveform: got %0d wrong cycles expected 0", mism);
      end
      check_bytes(CPB, "b2b");
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] w;
      bit e;
      w = $urandom();
      sel = 1'b0;
      clear_model();
      model_word(w, 4'b0000);
      wait_ready("mid_reset");
      data = w;
`ifdef UART_GROUP_MASK_EN
      dis_in = 4'b0000;
`endif
      stb = 1'b1;
      @(posedge clk); #1;
      stb = 1'b0;
      repeat (57) begin
         @(posedge clk); #1;
      end
      e = exp_bits[57 / CPB];
      checks++;
      if (tx_s !== e || rdy_s !== 1'b0) begin
         failures++;
         $display("[TB] FAIL mid_reset pre: tx=%b rdy=%b expected tx=%b rdy=0", tx_s, rdy_s, e);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (tx_s !== 1'b1) begin
         failures++;
         $display("[TB] FAIL mid_reset tx: got %b expected 1", tx_s);
      end
      checks++;
      if (rdy_s !== 1'b1) begin
         failures++;
         $display("[TB] FAIL mid_reset rdy: got %b expected 1", rdy_s);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_word($urandom(), 4'b0000, CPB, -1, "after_reset");
   endtask

`ifdef UART_GROUP_MASK_EN
   task automatic test_group_mask();
      sel = 1'b0;
      run_word(32'h1234_5678, 4'b1010, CPB, -1, "mask_1010");
      run_word(32'h1234_5678, 4'b1111, CPB, -1, "mask_1111");
      for (int i = 0; i < 3; i++) run_word($urandom(), 4'($urandom_range(0, 15)), CPB, -1, "mask_random");
      dis_in = 4'b0000;
   endtask
`endif

   task automatic test_cpb2();
      sel = 1'b1;
      run_word(32'h1234_5678, 4'b0000, CPB2, -1, "cpb2_12345678");
      run_word($urandom(), 4'b0000, CPB2, -1, "cpb2_random");
      sel = 1'b0;
   endtask

   initial begin
      sel = 1'b0;
`ifdef UART_GROUP_MASK_EN
      dis_in = 4'b0000;
`endif
      test_reset();
      test_word();
      test_ignored_strobe();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef UART_GROUP_MASK_EN
      test_group_mask();
`endif
      test_cpb2();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
